// File: rtl/booth4_pkg.sv
// Shared types and helpers for the sequential radix-4 Booth multiplier.
package booth4_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    P1   = 3'd1,
    P2   = 3'd2,
    M1   = 3'd3,
    M2   = 3'd4
  } digit_t;

  // Radix-4 steps needed to consume an NB+1 bit extended multiplier.
  function automatic int unsigned n_iter(input int unsigned nb);
    return (nb + 2) / 2;
  endfunction

endpackage

// File: rtl/booth4_recoder.sv
// Radix-4 Booth digit recoder: maps a 3-bit multiplier window to a signed addend.
module booth4_recoder
  import booth4_pkg::*;
#(
  parameter int NB = 8
) (
  input  logic [2:0]    window,
  input  logic [NB:0]   mcand,
  output logic [NB+2:0] addend
);

  digit_t      digit;
  logic [NB+2:0] m1;
  logic [NB+2:0] m2;

  assign m1 = {{2{mcand[NB]}}, mcand};
  assign m2 = {mcand[NB], mcand, 1'b0};

  always_comb begin
    digit = ZERO;
    unique case (window)
      3'b001, 3'b010: digit = P1;
      3'b011:         digit = P2;
      3'b100:         digit = M2;
      3'b101, 3'b110: digit = M1;
      default:        digit = ZERO;
    endcase
  end

  always_comb begin
    addend = '0;
    unique case (digit)
      P1:      addend = m1;
      P2:      addend = m2;
      M1:      addend = -m1;
      M2:      addend = -m2;
      default: addend = '0;
    endcase
  end

endmodule

// File: rtl/booth4_mult_seq.sv
// Sequential radix-4 Booth multiplier with per-operand signedness and
// valid/ready handshakes; retires two multiplier bits per clock.
module booth4_mult_seq
  import booth4_pkg::*;
#(
  parameter int NB = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [NB-1:0]   a,
  input  logic [NB-1:0]   b,
  input  logic            a_signed,
  input  logic            b_signed,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*NB-1:0] product
);

  localparam int unsigned NI = n_iter(NB);
  localparam int unsigned LW = 2 * NI;
  localparam int unsigned HW = NB + 3;
  localparam int unsigned IW = $clog2(NI + 1);

  state_t               state_q, state_d;
  logic [NB:0]          mcand_q;
  logic [HW+LW-1:0]     acc_q;
  logic                 prev_q;
  logic [IW-1:0]        iter_q;
  logic [2*NB-1:0]      product_q;

  logic                 accept;
  logic                 last_step;
  logic [LW-1:0]        b_ext;
  logic [HW-1:0]        addend;
  logic [HW-1:0]        sum;
  logic [HW+LW-1:0]     acc_n;

  assign accept    = in_ready && in_valid;
  assign last_step = (iter_q == IW'(NI - 1));
  assign b_ext     = {{(LW - NB){b_signed & b[NB-1]}}, b};

  booth4_recoder #(.NB(NB)) u_recoder (
    .window (acc_q[1:0] == 2'b00 ? {2'b00, prev_q} : {acc_q[1:0], prev_q}),
    .mcand  (mcand_q),
    .addend (addend)
  );

  // Add the digit into the high part, then arithmetic shift the whole accumulator by 2.
  assign sum   = acc_q[HW+LW-1:LW] + addend;
  assign acc_n = {{2{sum[HW-1]}}, sum, acc_q[LW-1:2]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = RUN;
      end
      RUN:  if (last_step) state_d = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q   <= '0;
      acc_q     <= '0;
      prev_q    <= 1'b0;
      iter_q    <= '0;
      product_q <= '0;
    end else if (accept) begin
      mcand_q <= {a_signed & a[NB-1], a};
      acc_q   <= {{HW{1'b0}}, b_ext};
      prev_q  <= 1'b0;
      iter_q  <= '0;
    end else if (state_q == RUN) begin
      acc_q  <= acc_n;
      prev_q <= acc_q[1];
      iter_q <= iter_q + IW'(1);
      if (last_step) product_q <= acc_n[2*NB-1:0];
    end
  end

  assign product = product_q;

endmodule

// File: tb/tb_booth4_mult_seq.sv
// Scoreboard bench for booth4_mult_seq at NB=8 and NB=5 with directed vectors.
module tb_booth4_mult_seq;

  typedef struct {
    logic [15:0] prod;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int compared   = 0;
  int mismatched = 0;

  logic        in_valid8, in_ready8, a_signed8, b_signed8, out_valid8, out_ready8;
  logic [7:0]  a8, b8;
  logic [15:0] product8;

  logic        in_valid5, in_ready5, a_signed5, b_signed5, out_valid5, out_ready5;
  logic [4:0]  a5, b5;
  logic [9:0]  product5;

  booth4_mult_seq #(.NB(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .a_signed(a_signed8), .b_signed(b_signed8),
    .out_valid(out_valid8), .out_ready(out_ready8), .product(product8)
  );

  booth4_mult_seq #(.NB(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid5), .in_ready(in_ready5),
    .a(a5), .b(b5), .a_signed(a_signed5), .b_signed(b_signed5),
    .out_valid(out_valid5), .out_ready(out_ready5), .product(product5)
  );

  exp_t exp8_q[$];
  exp_t exp5_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    compared++;
    if (act !== want) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  // Monitors: latency counts rising edges from the accept edge (inclusive) to the out_valid edge.
  int   acc_cyc8 = 0, acc_cyc5 = 0;
  logic ov_prev8 = 1'b0, ov_prev5 = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) ov_prev8 = 1'b0;
    else begin
      if (in_valid8 && in_ready8) acc_cyc8 = cyc + 1;
      if (out_valid8 && !ov_prev8) begin
        if (exp8_q.size() == 0) check("unexpected_valid8", 32'(out_valid8), 32'd0);
        else check("latency8", 32'(cyc - acc_cyc8 + 1), 32'(exp8_q[0].lat));
      end
      if (out_valid8 && out_ready8 && exp8_q.size() > 0) begin
        e = exp8_q.pop_front();
        check("product8", 32'(product8), 32'(e.prod));
      end
      ov_prev8 = out_valid8;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) ov_prev5 = 1'b0;
    else begin
      if (in_valid5 && in_ready5) acc_cyc5 = cyc + 1;
      if (out_valid5 && !ov_prev5) begin
        if (exp5_q.size() == 0) check("unexpected_valid5", 32'(out_valid5), 32'd0);
        else check("latency5", 32'(cyc - acc_cyc5 + 1), 32'(exp5_q[0].lat));
      end
      if (out_valid5 && out_ready5 && exp5_q.size() > 0) begin
        e = exp5_q.pop_front();
        check("product5", 32'(32'(product5)), 32'(e.prod));
      end
      ov_prev5 = out_valid5;
    end
  end

  int last_acc8 = 0;

  task automatic issue8(input logic [7:0] av, input logic [7:0] bv, input logic as, input logic bs,
                        input bit push, input logic [15:0] prod);
    int n = 0;
    exp_t e;
    a8 = av; b8 = bv; a_signed8 = as; b_signed8 = bs; in_valid8 = 1'b1;
    while (!in_ready8 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) check("in_ready8_timeout", 32'(in_ready8), 32'd1);
    if (push) begin
      e.prod = prod; e.lat = 6;
      exp8_q.push_back(e);
    end
    @(posedge clk); #1;
    last_acc8 = cyc;
    in_valid8 = 1'b0;
  endtask

  task automatic issue5(input logic [4:0] av, input logic [4:0] bv, input logic as, input logic bs,
                        input logic [15:0] prod);
    int n = 0;
    exp_t e;
    a5 = av; b5 = bv; a_signed5 = as; b_signed5 = bs; in_valid5 = 1'b1;
    while (!in_ready5 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) check("in_ready5_timeout", 32'(in_ready5), 32'd1);
    e.prod = prod; e.lat = 4;
    exp5_q.push_back(e);
    @(posedge clk); #1;
    in_valid5 = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp8_q.size() != 0 || exp5_q.size() != 0) && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 200) check("drain_timeout", 32'(exp8_q.size() + exp5_q.size()), 32'd0);
  endtask

  initial begin
    int prev_acc;
    int n;
    rst_n = 1'b0;
    in_valid8 = 1'b0; a8 = '0; b8 = '0; a_signed8 = 1'b0; b_signed8 = 1'b0; out_ready8 = 1'b1;
    in_valid5 = 1'b0; a5 = '0; b5 = '0; a_signed5 = 1'b0; b_signed5 = 1'b0; out_ready5 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready8), 32'd1);
    check("rst_out_valid", 32'(out_valid8), 32'd0);
    check("rst_product", 32'(product8), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset mid-RUN: operation abandoned, no result afterwards.
    issue8(8'h12, 8'h34, 1'b0, 1'b0, 1'b0, 16'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrun_out_valid", 32'(out_valid8), 32'd0);
    check("midrun_in_ready", 32'(in_ready8), 32'd1);
    check("midrun_product", 32'(product8), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("no_stale_valid", 32'(out_valid8), 32'd0);

    // Back-to-back operations with out_ready held high.
    issue8(8'h80, 8'h80, 1'b1, 1'b1, 1'b1, 16'h4000);
    prev_acc = last_acc8;
    issue8(8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1, 16'hFE01);
    check("throughput_a", 32'(last_acc8 - prev_acc), 32'd7);
    prev_acc = last_acc8;
    issue8(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b1, 16'hFF01);
    check("throughput_b", 32'(last_acc8 - prev_acc), 32'd7);
    issue8(8'h05, 8'h03, 1'b0, 1'b0, 1'b1, 16'h000F);
    drain();

    // Backpressure: result must hold and new operands must be ignored.
    out_ready8 = 1'b0;
    issue8(8'h07, 8'hFD, 1'b1, 1'b1, 1'b1, 16'hFFEB);
    n = 0;
    while (!out_valid8 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) check("out_valid8_timeout", 32'(out_valid8), 32'd1);
    for (int i = 0; i < 4; i++) begin
      a8 = 8'h55; b8 = 8'h33; a_signed8 = 1'b0; b_signed8 = 1'b0; in_valid8 = 1'b1;
      @(posedge clk); #1;
      check("bp_out_valid", 32'(out_valid8), 32'd1);
      check("bp_in_ready", 32'(in_ready8), 32'd0);
      check("bp_product", 32'(product8), 32'hFFEB);
    end
    in_valid8 = 1'b0;
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    check("bp_release_in_ready", 32'(in_ready8), 32'd1);
    check("bp_release_out_valid", 32'(out_valid8), 32'd0);
    repeat (10) @(posedge clk);
    #1;
    check("bp_ignored_ops", 32'(out_valid8), 32'd0);
    check("bp_product_held", 32'(product8), 32'hFFEB);

    // Odd width NB=5, N_ITER=3.
    issue5(5'h10, 5'h0F, 1'b1, 1'b0, 16'h0310);
    issue5(5'h0F, 5'h0F, 1'b0, 1'b0, 16'h00E1);
    issue5(5'h10, 5'h10, 1'b1, 1'b1, 16'h0100);
    drain();
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
